// File: rtl/sprite_pkg.sv
// Shared sprite/frame-buffer constants and the renderer state type.
package sprite_pkg;

  localparam logic [4:0] TRANSPARENT_CODE = 5'h15;
  localparam int         SCREEN_W         = 640;
  localparam int         SCREEN_H         = 480;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } sprite_state_t;

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous frame_Clk into the Clk domain and emits a
// one-cycle pulse on each synchronised rising edge.
module vsync_edge_sync (
  input  logic Clk,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Free-running on purpose: an edge that coincides with Reset is consumed
  // rather than replayed once Reset drops.
  always_ff @(posedge Clk) begin
    r_sync1 <= i_async;
    r_sync2 <= r_sync1;
    r_sync3 <= r_sync2;
  end

  assign o_edge = r_sync2 & ~r_sync3;

endmodule

// File: rtl/sprite_pixel_gen.sv
// Per-pixel sprite renderer: hit test and ROM addressing in stage 0,
// ROM fetch in stage 1, palette code to the frame buffer in stage 2.
module sprite_pixel_gen
  import sprite_pkg::*;
#(
  parameter int         SPR_W       = 24,
  parameter int         SPR_H       = 45,
  parameter int         N_FRAMES    = 4,
  parameter int         FRAME_DIV   = 8,
  parameter int         ADDR_W      = 13,
  parameter logic [4:0] TRANSPARENT = TRANSPARENT_CODE
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_Clk,
  input  logic              blank,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              Facing,
  input  logic              Walking,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        SpritePixel,
  output logic              SpriteValid
);

  localparam int FI_W = (N_FRAMES  > 1) ? $clog2(N_FRAMES)  : 1;
  localparam int DC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  sprite_state_t     r_state;
  logic [9:0]        r_sx;
  logic [9:0]        r_sy;
  logic              r_fc;
  logic [FI_W-1:0]   r_frame_idx;
  logic [DC_W-1:0]   r_div_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit1;
  logic [4:0]        r_pixel;
  logic              r_valid;

  logic              w_vs_edge;
  logic              w_hit;
  logic [9:0]        w_col;
  logic [9:0]        w_col_m;
  logic [9:0]        w_row;
  logic [ADDR_W-1:0] w_addr;

  vsync_edge_sync u_vsync (
    .Clk     (Clk),
    .i_async (frame_Clk),
    .o_edge  (w_vs_edge)
  );

  // 11-bit bounds so a box overhanging the right/bottom edge clips instead of wrapping.
  assign w_hit = ({1'b0, DrawX} >= {1'b0, r_sx}) &&
                 ({1'b0, DrawX} <  ({1'b0, r_sx} + 11'(SPR_W))) &&
                 ({1'b0, DrawY} >= {1'b0, r_sy}) &&
                 ({1'b0, DrawY} <  ({1'b0, r_sy} + 11'(SPR_H)));

  assign w_col   = DrawX - r_sx;
  assign w_col_m = r_fc ? (10'(SPR_W - 1) - w_col) : w_col;
  assign w_row   = DrawY - r_sy;
  assign w_addr  = (ADDR_W'(r_frame_idx) * ADDR_W'(SPR_W * SPR_H))
                 + (ADDR_W'(w_row) * ADDR_W'(SPR_W))
                 + ADDR_W'(w_col_m);

  // Frame-rate state: FSM, per-frame latch of position/facing, walk animation.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= WAIT_FRAME;
      r_sx        <= 10'd0;
      r_sy        <= 10'd0;
      r_fc        <= 1'b0;
      r_frame_idx <= '0;
      r_div_cnt   <= '0;
    end else if (w_vs_edge) begin
      r_state <= RUN;
      r_sx    <= SpriteX;
      r_sy    <= SpriteY;
      r_fc    <= Facing;
      if (!Walking) begin
        r_div_cnt   <= '0;
        r_frame_idx <= '0;
      end else if (r_div_cnt == DC_W'(FRAME_DIV - 1)) begin
        r_div_cnt   <= '0;
        r_frame_idx <= (r_frame_idx == FI_W'(N_FRAMES - 1)) ? '0 : r_frame_idx + FI_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DC_W'(1);
      end
    end
  end

  // Pixel pipeline; rom_addr holds outside the box to avoid needless ROM toggling.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_pixel    <= TRANSPARENT;
      r_valid    <= 1'b0;
    end else begin
      if (w_hit) begin
        r_rom_addr <= w_addr;
      end
      r_hit1  <= w_hit & blank & (r_state == RUN);
      r_pixel <= r_hit1 ? rom_data : TRANSPARENT;
      r_valid <= r_hit1 && (rom_data != TRANSPARENT);
    end
  end

  assign rom_addr    = r_rom_addr;
  assign SpritePixel = r_pixel;
  assign SpriteValid = r_valid;

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Randomised bench for sprite_pixel_gen against a frame-level reference model.
module tb_sprite_pixel_gen;

  localparam int SPR_W = 24;
  localparam int SPR_H = 45;
  localparam int FSZ   = SPR_W * SPR_H;
  localparam int TCODE = 21;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_Clk = 1'b0;
  logic        blank = 1'b0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic [9:0]  SpriteX = 10'd0;
  logic [9:0]  SpriteY = 10'd0;
  logic        Facing = 1'b0;
  logic        Walking = 1'b0;
  logic [12:0] rom_addr;
  logic [4:0]  rom_data;
  logic [4:0]  SpritePixel;
  logic        SpriteValid;

  logic [4:0]  rom_mem [0:8191];

  assign rom_data = rom_mem[rom_addr];

  always #5 Clk = ~Clk;

  sprite_pixel_gen dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_Clk   (frame_Clk),
    .blank       (blank),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .SpriteX     (SpriteX),
    .SpriteY     (SpriteY),
    .Facing      (Facing),
    .Walking     (Walking),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .SpritePixel (SpritePixel),
    .SpriteValid (SpriteValid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the frame buffer should see this frame.
  int m_run, m_sx, m_sy, m_fc, m_walk_n, m_addr;
  bit m_addr_known;
  int pend_pix;
  bit pend_ok;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    blank = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
    pend_ok = 1'b0;
  endtask

  task automatic drive(input int x, input int y, input bit b);
    int  fi, col, e_pix;
    bit  hit;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    fi  = (m_walk_n / 8) % 4;
    hit = (x >= m_sx) && (x < m_sx + SPR_W) && (y >= m_sy) && (y < m_sy + SPR_H);
    if (hit) begin
      col = x - m_sx;
      if (m_fc != 0) col = SPR_W - 1 - col;
      m_addr = fi * FSZ + (y - m_sy) * SPR_W + col;
      m_addr_known = 1'b1;
    end
    e_pix = (hit && b && m_run != 0) ? int'(rom_mem[m_addr]) : TCODE;
    @(posedge Clk);
    #1;
    if (m_addr_known) check_eq("rom_addr", int'(rom_addr), m_addr);
    if (pend_ok) begin
      check_eq("pixel", int'(SpritePixel), pend_pix);
      check_eq("valid", int'(SpriteValid), int'(pend_pix != TCODE));
    end
    pend_pix = e_pix;
    pend_ok  = 1'b1;
  endtask

  task automatic vsync();
    frame_Clk = 1'b1;
    idle(4);
    frame_Clk = 1'b0;
    idle(4);
    m_sx  = int'(SpriteX);
    m_sy  = int'(SpriteY);
    m_fc  = int'(Facing);
    m_run = 1;
    m_walk_n = Walking ? m_walk_n + 1 : 0;
    m_addr_known = 1'b0;
  endtask

  task automatic model_reset();
    m_run = 0; m_sx = 0; m_sy = 0; m_fc = 0; m_walk_n = 0;
    m_addr = 0;
    pend_ok = 1'b0;
  endtask

  initial begin
    int x, y;
    for (int i = 0; i < 8192; i++) rom_mem[i] = 5'($urandom_range(0, 31));
    rom_mem[5]   = 5'h15;
    rom_mem[245] = 5'h15;
    model_reset();
    m_addr_known = 1'b0;

    // Reset values while Reset is held
    Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check_eq("rst_pixel", int'(SpritePixel), TCODE);
    check_eq("rst_valid", int'(SpriteValid), 0);
    check_eq("rst_addr", int'(rom_addr), 0);
    Reset = 1'b0;
    m_addr_known = 1'b1;

    // No vsync yet: everything transparent, including inside the origin box
    for (int i = 0; i < 300; i++) begin
      x = (i < 100) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 639));
      y = (i < 100) ? int'($urandom_range(0, 50)) : int'($urandom_range(0, 479));
      drive(x, y, 1'b1);
    end

    // Basic placement and right-edge boundary
    SpriteX = 10'd100; SpriteY = 10'd50; Facing = 1'b0; Walking = 1'b0;
    vsync();
    drive(100, 50, 1'b1);
    check_eq("origin_addr", int'(rom_addr), 0);
    drive(123, 50, 1'b1);
    check_eq("col23_addr", int'(rom_addr), 23);
    drive(124, 50, 1'b1);
    drive(99, 50, 1'b1);
    drive(100, 94, 1'b1);
    drive(100, 95, 1'b1);
    drive(0, 0, 1'b0);

    // Mirror, then a mid-frame position change that must not take effect
    Facing = 1'b1;
    vsync();
    drive(100, 51, 1'b1);
    check_eq("mirror_addr", int'(rom_addr), 47);
    SpriteX = 10'd200;
    drive(101, 51, 1'b1);
    drive(100, 51, 1'b1);
    check_eq("midframe_addr", int'(rom_addr), 47);
    drive(0, 0, 1'b0);

    // Walk animation over 40 vsyncs
    SpriteX = 10'd100; Facing = 1'b0; Walking = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      vsync();
      drive(100, 50, 1'b1);
      if (i == 8)  check_eq("anim_f1_addr", int'(rom_addr), 1080);
      if (i == 16) check_eq("anim_f2_addr", int'(rom_addr), 2160);
      if (i == 32) check_eq("anim_wrap_addr", int'(rom_addr), 0);
      drive(0, 0, 1'b0);
    end
    Walking = 1'b0;
    vsync();
    drive(100, 50, 1'b1);
    check_eq("walk_stop_addr", int'(rom_addr), 0);
    drive(0, 0, 1'b0);

    // Right-edge overhang clips without wrap; in-box transparent ROM word
    SpriteX = 10'd630; SpriteY = 10'd100;
    vsync();
    drive(639, 110, 1'b1);
    check_eq("clip_col9_addr", int'(rom_addr), 249);
    drive(0, 110, 1'b1);
    drive(635, 110, 1'b1);
    drive(639, 144, 1'b1);
    drive(0, 0, 1'b0);
    drive(0, 0, 1'b0);

    // Reset coincident with vs_edge while running
    frame_Clk = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    idle(3);
    frame_Clk = 1'b0;
    idle(4);
    m_addr_known = 1'b0;
    for (int i = 0; i < 60; i++) drive(int'($urandom_range(0, 23)), int'($urandom_range(0, 44)), 1'b1);
    drive(635, 110, 1'b1);
    drive(639, 110, 1'b1);
    drive(0, 0, 1'b0);

    // First vsync after reset: animation restarts from frame 0; blank low in box
    SpriteX = 10'd100; SpriteY = 10'd50; Walking = 1'b1;
    vsync();
    drive(100, 50, 1'b1);
    check_eq("post_rst_addr", int'(rom_addr), 0);
    drive(105, 60, 1'b0);
    drive(106, 60, 1'b0);
    drive(0, 0, 1'b0);

    // Randomised frames
    for (int v = 0; v < 20; v++) begin
      SpriteX = 10'($urandom_range(0, 639));
      SpriteY = 10'($urandom_range(0, 479));
      Facing  = 1'($urandom_range(0, 1));
      Walking = ($urandom_range(0, 3) != 0);
      vsync();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          x = m_sx - 3 + int'($urandom_range(0, 30));
          y = m_sy - 3 + int'($urandom_range(0, 51));
        end else begin
          x = int'($urandom_range(0, 639));
          y = int'($urandom_range(0, 479));
        end
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        drive(x, y, ($urandom_range(0, 7) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
